// File: rtl/irq_arbiter_vec.sv
// Machine-level interrupt arbiter: level/edge capture, mie masking, priority grant, mcause/id registers.
// Optional IRQ_ROUND_ROBIN_EN replaces fixed lowest-index priority with a rotating search pointer.
module irq_arbiter_vec #(
  parameter int               N_IRQ      = 6,
  parameter int               CAUSE_BASE = 16,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
  localparam int              ID_W       = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [N_IRQ-1:0] int_fin_o,
  output logic [31:0]      mcause_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic             busy_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] req_q, pend_q, pend_d, fin_q, fin_d, clr;
  logic [N_IRQ-1:0] rise, eligible;
  logic [ID_W-1:0]  id_q, id_d, winner;
  logic [31:0]      mcause_q, mcause_d;
  logic             int_q, int_d, found;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]  rr_q, rr_d;
  int               idx;
`endif

  assign rise     = int_req_i & ~req_q;
  assign eligible = mie_i & ((EDGE_MASK & pend_q) | (~EDGE_MASK & int_req_i));

  // Winner search; only consulted when eligible is non-zero.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
    idx    = 0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_IRQ) idx = idx - N_IRQ;
      if (!found && eligible[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
`else
    for (int i = 0; i < N_IRQ; i++) begin
      if (!found && eligible[i]) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    int_d    = 1'b0;
    fin_d    = '0;
    clr      = '0;
    id_d     = id_q;
    mcause_d = mcause_q;
`ifdef IRQ_ROUND_ROBIN_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = BUSY;
          int_d    = 1'b1;
          id_d     = winner;
          mcause_d = {1'b1, 31'(CAUSE_BASE) + 31'(winner)};
`ifdef IRQ_ROUND_ROBIN_EN
          rr_d     = (winner == ID_W'(N_IRQ - 1)) ? '0 : winner + ID_W'(1);
`endif
        end
      end
      BUSY: begin
        if (int_rst_i) begin
          state_d = IDLE;
          fin_d   = N_IRQ'(1) << id_q;
          clr     = fin_d;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh rising edge in the clearing cycle survives the clear.
    pend_d = ((pend_q & ~clr) | rise) & EDGE_MASK;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      pend_q   <= '0;
      fin_q    <= '0;
      id_q     <= '0;
      mcause_q <= '0;
      int_q    <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= int_req_i;
      pend_q   <= pend_d;
      fin_q    <= fin_d;
      id_q     <= id_d;
      mcause_q <= mcause_d;
      int_q    <= int_d;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign int_o     = int_q;
  assign int_fin_o = fin_q;
  assign mcause_o  = mcause_q;
  assign irq_id_o  = id_q;
  assign busy_o    = (state_q == BUSY);

endmodule
